// File: rtl/hex_display_scanner.sv
// Multiplexed hex 7-segment scanner with leading-zero and enable blanking.
// Optional digit blinking is compiled in with DISPLAY_BLINK_EN.
module hex_display_scanner #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blink,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [0:6]            segments,
  output logic                  dp
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [TW-1:0]         r_tick;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_val;
  logic [N_DIGITS-1:0]   r_dp;

  logic                  w_adv;
  logic [3:0]            w_nib;
  logic                  w_dp_sel;
  logic                  w_lz;
  logic                  w_blink_off;
  logic                  w_blank;
  logic [N_DIGITS-1:0]   w_an;

  assign w_adv = (r_tick == TW'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else if (w_adv) begin
      r_tick <= '0;
      if (r_idx == IW'(N_DIGITS - 1))
        r_idx <= '0;
      else
        r_idx <= r_idx + 1'b1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_val <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_val <= value;
      r_dp  <= dp_in;
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [N_DIGITS-1:0] r_blink;
  logic [BW-1:0]       r_slot;
  logic                r_phase;

  // Phase flips once every BLINK_DIV digit-slot advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink <= '0;
      r_slot  <= '0;
      r_phase <= 1'b0;
    end else begin
      if (load)
        r_blink <= blink;
      if (w_adv) begin
        if (r_slot == BW'(BLINK_DIV - 1)) begin
          r_slot  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_blink_off = 1'b0;
    for (int i = 0; i < N_DIGITS; i++)
      if (r_idx == IW'(i))
        w_blink_off = r_phase & r_blink[i];
  end
`else
  localparam int unused_blink_div = BLINK_DIV;
  logic w_unused_blink;
  assign w_unused_blink = ^blink;
  assign w_blink_off    = 1'b0;
`endif

  // Digit i is a leading zero when it and all higher nibbles are zero.
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_lz     = 1'b0;
    w_an     = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib    = r_val[4*i +: 4];
        w_dp_sel = r_dp[i];
        w_lz     = (i != 0) && ((r_val >> (4*i)) == '0);
        w_an[i]  = 1'b0;
      end
    end
  end

  assign w_blank = ~enable | (blank_lz & w_lz) | w_blink_off;

  function automatic logic [0:6] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b0000001;
      4'h1:    seg7 = 7'b1001111;
      4'h2:    seg7 = 7'b0010010;
      4'h3:    seg7 = 7'b0000110;
      4'h4:    seg7 = 7'b1001100;
      4'h5:    seg7 = 7'b0100100;
      4'h6:    seg7 = 7'b0100000;
      4'h7:    seg7 = 7'b0001111;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0001100;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b1100000;
      4'hC:    seg7 = 7'b0110001;
      4'hD:    seg7 = 7'b1000010;
      4'hE:    seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Whole output word is registered together so anodes never overlap.
  always_ff @(posedge clk) begin
    if (reset || w_blank) begin
      anodes   <= '1;
      segments <= '1;
      dp       <= 1'b1;
    end else begin
      anodes   <= w_an;
      segments <= seg7(w_nib);
      dp       <= ~w_dp_sel;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: directed literal checks plus a
// cycle-count based reference model compared on every cycle.
module tb_hex_display_scanner;

  localparam int ND   = 4;
  localparam int RDIV = 4;
  localparam int BDIV = 1;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blink;
  logic        blank_lz;
  logic        enable;
  logic [3:0]  anodes;
  logic [0:6]  segments;
  logic        dp;

  int vectors;
  int miscompares;

  hex_display_scanner #(
    .N_DIGITS(ND),
    .REFRESH_DIV(RDIV),
    .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .dp_in(dp_in),
    .blink(blink),
    .blank_lz(blank_lz),
    .enable(enable),
    .anodes(anodes),
    .segments(segments),
    .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:6] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: position derived from edges elapsed since reset.
  int          m_e;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_bl;
  bit          m_valid = 1'b0;
  logic [3:0]  exp_an;
  logic [0:6]  exp_seg;
  logic        exp_dp;

  always @(posedge clk) begin
    int         k;
    bit         bl;
    logic [3:0] nib;
    if (reset) begin
      m_e     <= 0;
      m_val   <= '0;
      m_dp    <= '0;
      m_bl    <= '0;
      exp_an  <= '1;
      exp_seg <= '1;
      exp_dp  <= 1'b1;
      m_valid <= 1'b1;
    end else begin
      k   = (m_e / RDIV) % ND;
      nib = 4'((m_val >> (4*k)) & 16'hF);
      bl  = !enable;
      if (blank_lz && k != 0 && (m_val >> (4*k)) == 16'h0)
        bl = 1'b1;
`ifdef DISPLAY_BLINK_EN
      if ((((m_e / RDIV) / BDIV) % 2) == 1 && m_bl[k])
        bl = 1'b1;
`endif
      if (bl) begin
        exp_an  <= '1;
        exp_seg <= '1;
        exp_dp  <= 1'b1;
      end else begin
        exp_an  <= 4'(~(4'b0001 << k));
        exp_seg <= seg_tab[nib];
        exp_dp  <= ~m_dp[k];
      end
      m_e <= m_e + 1;
      if (load) begin
        m_val <= value;
        m_dp  <= dp_in;
        m_bl  <= blink;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if (anodes !== exp_an || segments !== exp_seg ||
          dp !== exp_dp || $countones(~anodes) > 1) begin
        miscompares++;
        $display("FAIL model t=%0t an=%b/%b seg=%b/%b dp=%b/%b",
                 $time, anodes, exp_an, segments, exp_seg, dp, exp_dp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic reset_release();
    reset = 1'b1;
    load  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_blank(input string name);
    chk({name, "_an"}, 32'(anodes), 32'hF);
    chk({name, "_seg"}, 32'(segments), 32'h7F);
    chk({name, "_dp"}, 32'(dp), 32'h1);
  endtask

  // Load at first edge after reset, then check the whole second scan.
  task automatic run_scan(input string name, input logic [15:0] v,
                          input logic [3:0] d, input logic b,
                          input logic [15:0] an_all,
                          input logic [27:0] seg_all,
                          input logic [3:0] dp_all);
    reset_release();
    value    = v;
    dp_in    = d;
    blank_lz = b;
    enable   = 1'b1;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (15) @(negedge clk);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      chk({name, "_an"}, 32'(anodes), 32'(an_all[4*(s/4) +: 4]));
      chk({name, "_seg"}, 32'(segments), 32'(seg_all[7*(s/4) +: 7]));
      chk({name, "_dp"}, 32'(dp), 32'(dp_all[s/4]));
    end
  endtask

  initial begin
    logic [15:0] mask;
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b1;
    value    = '0;
    load     = 1'b0;
    dp_in    = '0;
    blink    = 4'b0001;
    blank_lz = 1'b0;
    enable   = 1'b1;
    @(negedge clk);
    chk_blank("reset");

    run_scan("scan1A3F", 16'h1A3F, 4'b0100, 1'b0,
             {4'b0111, 4'b1011, 4'b1101, 4'b1110},
             {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000},
             4'b1011);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_blank("enable_off");
    end
    enable = 1'b1;
    @(negedge clk);
    chk("resume_d0", 32'(anodes), 32'hE);
    @(negedge clk);
    chk("resume_d1", 32'(anodes), 32'hD);

    run_scan("lz0005", 16'h0005, 4'b0000, 1'b1,
             {4'b1111, 4'b1111, 4'b1111, 4'b1110},
             {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100},
             4'b1111);
    run_scan("lz0000", 16'h0000, 4'b0000, 1'b1,
             {4'b1111, 4'b1111, 4'b1111, 4'b1110},
             {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001},
             4'b1111);

    blank_lz = 1'b0;
    reset_release();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_blank("mid_reset");
    reset = 1'b0;
    for (int i = 0; i < RDIV; i++) begin
      @(negedge clk);
      chk("post_reset_d0", 32'(anodes), 32'hE);
    end
    @(negedge clk);
    chk("post_reset_d1", 32'(anodes), 32'hD);

    reset_release();
    repeat (3) @(negedge clk);
    value = 16'h0020;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("adv_old_an", 32'(anodes), 32'hE);
    chk("adv_old_seg", 32'(segments), 32'(7'b0000001));
    @(negedge clk);
    chk("adv_new_an", 32'(anodes), 32'hD);
    chk("adv_new_seg", 32'(segments), 32'(7'b0010010));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 199) == 0);
      load   = ($urandom_range(0, 3) == 0);
      mask   = 16'hFFFF >> (4 * $urandom_range(0, 4));
      value  = 16'($urandom) & mask;
      dp_in  = 4'($urandom);
      blink  = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 31) == 0)
        blank_lz = ~blank_lz;
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
